lcd_cmd_engine: RTL and testbench

//  Parametrised successor to the Nios LCD conduit outputs. Buffers CPU-issued HD44780 bytes in a FIFO
//  and replays them with programmable setup/enable/hold/execution timing. Supports 8-bit or 4-bit bus mode
//  and a long wait for clear/home. Sits between the Nios LCD slave and the LCD pins; the CPU never busy-waits.

---
 rtl/nios_lcd_pkg.sv | 38 +++
 rtl/lcd_sync_fifo.sv | 76 +++++++
 rtl/lcd_cmd_engine.sv | 185 ++++++++++++++++++
 tb/tb_lcd_cmd_engine.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_lcd_pkg.sv
// ----------------------------------------------------------------------------
// nios_lcd_pkg
//   Shared definitions for the LCD command engine: the replay FSM state
//   encoding, the HD44780 instruction codes that need the long post-command
//   wait (clear display / return home), and small helper functions.
//   No ports; imported by lcd_sync_fifo and lcd_cmd_engine.
// ----------------------------------------------------------------------------
package nios_lcd_pkg;

    // Replay FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_EXEC
    } lcd_state_t;

    // Queued entry layout: {rs, data}.
    localparam int LCD_ENTRY_W = 9;

    // Instructions whose execution time is far longer than every other one.
    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
    localparam logic [7:0] LCD_CMD_HOME_ALT = 8'h03;  // home with don't-care bit 0 set

    // True when a byte is a clear/home instruction (rs=0) and needs the long wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (!rs) && ((data == LCD_CMD_CLEAR) ||
                         (data == LCD_CMD_HOME)  ||
                         (data == LCD_CMD_HOME_ALT));
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_sync_fifo.sv
// ----------------------------------------------------------------------------
// lcd_sync_fifo
//   Single-clock FIFO holding queued LCD bytes. Head entry is visible
//   combinationally so the consumer can load it onto the bus on the same edge
//   that pops it.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     push, push_data write request (ignored while full or during flush)
//     pop             consume head (ignored while empty)
//     flush           drop every queued entry (rd := wr)
//     head_data       current head entry
//     level           occupancy 0..DEPTH
//     full, empty     status, derived from the pointer wrap bit
// ----------------------------------------------------------------------------
module lcd_sync_fifo
    import nios_lcd_pkg::*;
#(
    parameter  int WIDTH = LCD_ENTRY_W,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            // A pop on the same edge has already taken the head; everything
            // behind it, plus any simultaneous push, is discarded.
            rd_ptr_reg <= wr_ptr_reg;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Extra MSB distinguishes full (same index, different lap) from empty.
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head_data = mem[rd_ptr_reg[AW-1:0]];
    assign level     = LW'(wr_ptr_reg - rd_ptr_reg);

endmodule

// File: rtl/lcd_cmd_engine.sv
// ----------------------------------------------------------------------------
// lcd_cmd_engine
//   Buffers CPU-issued HD44780 bytes and replays them on the LCD pins with
//   programmable setup / enable-high / hold / execution timing, in 8-bit or
//   4-bit (two nibbles on lcd_data[7:4]) bus mode. Clear/home instructions get
//   a longer execution wait. The CPU only pushes; it never polls the panel.
//   Ports:
//     clk_clk, reset_reset_n   clock, asynchronous active-low reset
//     cmd_valid/cmd_ready      push handshake (ready = FIFO not full)
//     cmd_rs, cmd_data         byte to queue (rs=0 instruction, rs=1 data)
//     flush                    discard queued, not yet popped bytes
//     lcd_data/rs/rw/en        LCD bus (rw tied low)
//     busy                     FIFO non-empty or a byte still in flight
//     fifo_level               current FIFO occupancy
// ----------------------------------------------------------------------------
module lcd_cmd_engine
    import nios_lcd_pkg::*;
#(
    parameter  int FIFO_DEPTH    = 16,
    parameter  int BUS_4BIT      = 0,
    parameter  int SETUP_CYC     = 4,
    parameter  int EN_HIGH_CYC   = 25,
    parameter  int HOLD_CYC      = 2,
    parameter  int EXEC_CYC      = 2500,
    parameter  int LONG_EXEC_CYC = 82000,
    localparam int LEVEL_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_rs,
    input  logic [7:0]         cmd_data,
    input  logic               flush,
    output logic [7:0]         lcd_data,
    output logic               lcd_rs,
    output logic               lcd_rw,
    output logic               lcd_en,
    output logic               busy,
    output logic [LEVEL_W-1:0] fifo_level
);

    // One shared down-counter covers every timed phase; it is loaded with
    // (cycles - 1) and the phase ends on the cycle it reads zero.
    localparam int CNT_MAX = max_int(max_int(SETUP_CYC, EN_HIGH_CYC),
                                     max_int(max_int(HOLD_CYC, EXEC_CYC), LONG_EXEC_CYC));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LOAD     = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LOAD        = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD      = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LOAD      = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_EXEC_LOAD = CNT_W'(LONG_EXEC_CYC - 1);

    lcd_state_t             state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [3:0]             low_nib_reg;      // second nibble waiting in 4-bit mode
    logic                   low_pending_reg;  // first nibble of a split byte in flight
    logic                   long_reg;         // current byte needs the long EXEC wait

    logic [LCD_ENTRY_W-1:0] head_entry;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   cnt_zero;
    logic                   pop;
    logic [7:0]             first_bus;
    logic                   split_byte;

    lcd_sync_fifo #(
        .WIDTH (LCD_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .push      (cmd_valid),
        .push_data ({cmd_rs, cmd_data}),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_entry),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // First bus value after a pop: whole byte, or high nibble on [7:4].
    generate
        if (BUS_4BIT != 0) begin : g_bus4
            assign first_bus  = {head_entry[7:4], 4'h0};
            assign split_byte = 1'b1;
        end else begin : g_bus8
            assign first_bus  = head_entry[7:0];
            assign split_byte = 1'b0;
        end
    endgenerate

    assign cnt_zero = (cnt_reg == '0);

    // Pop from IDLE, or on the last EXEC cycle so queued bytes run back to
    // back without an idle cycle between them.
    assign pop = !fifo_empty &&
                 ((state_reg == ST_IDLE) || ((state_reg == ST_EXEC) && cnt_zero));

    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_reg != ST_IDLE);
    assign lcd_rw    = 1'b0;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            low_nib_reg     <= 4'h0;
            low_pending_reg <= 1'b0;
            long_reg        <= 1'b0;
            lcd_data        <= 8'h00;
            lcd_rs          <= 1'b0;
            lcd_en          <= 1'b0;
        end else if (pop) begin
            // Bus loads on the pop edge, so setup time counts from here.
            state_reg       <= ST_SETUP;
            cnt_reg         <= SETUP_LOAD;
            lcd_rs          <= head_entry[8];
            lcd_data        <= first_bus;
            lcd_en          <= 1'b0;
            low_nib_reg     <= head_entry[3:0];
            low_pending_reg <= split_byte;
            long_reg        <= is_long_cmd(head_entry[8], head_entry[7:0]);
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    cnt_reg <= '0;
                end
                ST_SETUP: begin
                    if (cnt_zero) begin
                        state_reg <= ST_EN_HI;
                        cnt_reg   <= EN_LOAD;
                        lcd_en    <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_EN_HI: begin
                    if (cnt_zero) begin
                        state_reg <= ST_HOLD;
                        cnt_reg   <= HOLD_LOAD;
                        lcd_en    <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_zero) begin
                        if (low_pending_reg) begin
                            // 4-bit mode: replay the low nibble with the same
                            // strobe timing before any execution wait.
                            state_reg       <= ST_SETUP;
                            cnt_reg         <= SETUP_LOAD;
                            lcd_data        <= {low_nib_reg, 4'h0};
                            low_pending_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_EXEC;
                            cnt_reg   <= long_reg ? LONG_EXEC_LOAD : EXEC_LOAD;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_EXEC: begin
                    // Bus stays on the last byte; the FIFO-non-empty case is
                    // handled by the pop branch above.
                    if (cnt_zero) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    lcd_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_engine.sv
// ----------------------------------------------------------------------------
// tb_lcd_cmd_engine
//   Directed scenarios plus a randomized push/flush phase for the LCD command
//   engine. An 8-bit instance is tracked every cycle by a queue-and-schedule
//   reference model; a 4-bit instance covers nibble replay.
// ----------------------------------------------------------------------------
module tb_lcd_cmd_engine;

    localparam int DEPTH = 4;
    localparam int S     = 2;
    localparam int E     = 3;
    localparam int H     = 1;
    localparam int X     = 10;
    localparam int LX    = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       v8 = 1'b0, rs8 = 1'b0, fl8 = 1'b0;
    logic [7:0] d8 = 8'h00;
    logic       ready8, lrs8, lrw8, len8, busy8;
    logic [7:0] ld8;
    logic [2:0] lvl8;

    // 4-bit instance
    logic       v4 = 1'b0, rs4 = 1'b0, fl4 = 1'b0;
    logic [7:0] d4 = 8'h00;
    logic       ready4, lrs4, lrw4, len4, busy4;
    logic [7:0] ld4;
    logic [2:0] lvl4;

    lcd_cmd_engine #(
        .FIFO_DEPTH(DEPTH), .BUS_4BIT(0), .SETUP_CYC(S), .EN_HIGH_CYC(E),
        .HOLD_CYC(H), .EXEC_CYC(X), .LONG_EXEC_CYC(LX)
    ) dut8 (
        .clk_clk(clk), .reset_reset_n(rst_n), .cmd_valid(v8), .cmd_ready(ready8),
        .cmd_rs(rs8), .cmd_data(d8), .flush(fl8), .lcd_data(ld8), .lcd_rs(lrs8),
        .lcd_rw(lrw8), .lcd_en(len8), .busy(busy8), .fifo_level(lvl8)
    );

    lcd_cmd_engine #(
        .FIFO_DEPTH(DEPTH), .BUS_4BIT(1), .SETUP_CYC(S), .EN_HIGH_CYC(E),
        .HOLD_CYC(H), .EXEC_CYC(X), .LONG_EXEC_CYC(LX)
    ) dut4 (
        .clk_clk(clk), .reset_reset_n(rst_n), .cmd_valid(v4), .cmd_ready(ready4),
        .cmd_rs(rs4), .cmd_data(d4), .flush(fl4), .lcd_data(ld4), .lcd_rs(lrs4),
        .lcd_rw(lrw4), .lcd_en(len4), .busy(busy4), .fifo_level(lvl4)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;   // index of the most recent rising edge

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model for dut8 ----------------
    // Each accepted byte is popped at max(push edge + 1, previous pop +
    // previous byte period); the bus shows the last popped byte and EN is
    // high for cycles [pop+S, pop+S+E).
    logic [8:0] mq[$];
    logic [8:0] m_last_byte   = 9'h000;
    int         m_last_pop    = -1000;
    int         m_last_period = 0;
    int         m_next_ok     = 0;

    function automatic int period8(input logic [8:0] b);
        bit long_cmd;
        long_cmd = (b[8] == 1'b0) && (b[7:0] >= 8'd1) && (b[7:0] <= 8'd3);
        return S + E + H + (long_cmd ? LX : X);
    endfunction

    always @(posedge clk) begin
        int sz;
        cyc = cyc + 1;
        if (!rst_n) begin
            mq.delete();
            m_last_byte   = 9'h000;
            m_last_pop    = -1000;
            m_last_period = 0;
            m_next_ok     = 0;
        end else begin
            sz = mq.size();
            if (sz > 0 && cyc >= m_next_ok) begin
                m_last_byte   = mq.pop_front();
                m_last_pop    = cyc;
                m_last_period = period8(m_last_byte);
                m_next_ok     = cyc + m_last_period;
            end
            if (fl8) mq.delete();
            else if (v8 && sz < DEPTH) mq.push_back({rs8, d8});
        end
    end

    // Every-cycle comparison of dut8 against the model.
    always @(negedge clk) begin
        int  sz;
        bit  exp_en, exp_busy;
        sz = mq.size();
        if (!rst_n) begin
            chk("rst_en", len8, 0);
            chk("rst_data", ld8, 0);
            chk("rst_rs", lrs8, 0);
            chk("rst_level", lvl8, 0);
            chk("rst_ready", ready8, 1);
            chk("rst_busy", busy8, 0);
        end else begin
            exp_en   = (cyc >= m_last_pop + S) && (cyc < m_last_pop + S + E);
            exp_busy = (sz > 0) || (cyc < m_last_pop + m_last_period);
            chk("mon_en", len8, exp_en);
            chk("mon_data", ld8, m_last_byte[7:0]);
            chk("mon_rs", lrs8, m_last_byte[8]);
            chk("mon_rw", lrw8, 0);
            chk("mon_level", lvl8, sz);
            chk("mon_ready", ready8, (sz < DEPTH));
            chk("mon_busy", busy8, exp_busy);
        end
    end

    // Advance to the falling edge of cycle k (k must be in the future).
    task automatic at_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int lim;
        lim = cyc + budget;
        while ((mq.size() != 0 || cyc < m_last_pop + m_last_period) && cyc < lim) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("idle_timeout", (mq.size() == 0 && cyc >= m_last_pop + m_last_period), 1);
        chk("idle_busy", busy8, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int lvl_exp[5] = '{1, 1, 2, 3, 4};
    int k;
    int p;

    initial begin
        // ---------------- reset ----------------
        #2 rst_n = 1'b0;
        #1;
        chk("reset_ready", ready8, 1);
        chk("reset_level", lvl8, 0);
        chk("reset_en4", len4, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle(20);

        // ---------------- 1: single data byte ----------------
        k = cyc;
        v8 = 1'b1; rs8 = 1'b1; d8 = 8'h41;
        at_cyc(k + 1); v8 = 1'b0;
        chk("t1_level_after_push", lvl8, 1);
        at_cyc(k + 2);
        chk("t1_data", ld8, 8'h41);
        chk("t1_rs", lrs8, 1);
        chk("t1_en_pop", len8, 0);
        at_cyc(k + 3); chk("t1_en_setup", len8, 0);
        at_cyc(k + 4); chk("t1_en_c3", len8, 1);
        at_cyc(k + 5); chk("t1_en_c4", len8, 1);
        at_cyc(k + 6); chk("t1_en_c5", len8, 1);
        at_cyc(k + 7); chk("t1_en_c6", len8, 0);
        at_cyc(k + 17); chk("t1_busy_exec", busy8, 1);
        at_cyc(k + 19); chk("t1_busy_c18", busy8, 0);
        $display("txn t1: byte 41 rs=1 replayed, pop at cycle %0d", k + 2);

        // ---------------- 2: long command spacing ----------------
        wait_idle(100);
        k = cyc;
        v8 = 1'b1; rs8 = 1'b0; d8 = 8'h01;
        at_cyc(k + 1); rs8 = 1'b0; d8 = 8'h38;
        at_cyc(k + 2); rs8 = 1'b1; d8 = 8'h06;
        chk("t2_first_data", ld8, 8'h01);
        chk("t2_first_rs", lrs8, 0);
        at_cyc(k + 3); v8 = 1'b0;
        at_cyc(k + 47); chk("t2_before_second", ld8, 8'h01);
        at_cyc(k + 48); chk("t2_second_data", ld8, 8'h38);
        at_cyc(k + 50); chk("t2_second_en", len8, 1);
        at_cyc(k + 63); chk("t2_before_third", ld8, 8'h38);
        at_cyc(k + 64); chk("t2_third_data", ld8, 8'h06);
        chk("t2_third_rs", lrs8, 1);
        $display("txn t2: clear gap 46, normal gap 16");

        // ---------------- 3: fill the FIFO ----------------
        wait_idle(200);
        k = cyc;
        for (int i = 0; i < 5; i++) begin
            v8 = 1'b1; rs8 = 1'b1; d8 = 8'h10 + 8'(i);
            at_cyc(k + 1 + i);
            chk("t3_level", lvl8, lvl_exp[i]);
        end
        chk("t3_ready_full", ready8, 0);
        v8 = 1'b0;
        for (int j = 1; j < 5; j++) begin
            at_cyc(k + 2 + 16 * j);
            chk("t3_order", ld8, 8'h10 + 8'(j));
        end
        $display("txn t3: five bytes back to back, level 1,1,2,3,4");

        // ---------------- 4: 4-bit bus mode ----------------
        k = cyc;
        v4 = 1'b1; rs4 = 1'b1; d4 = 8'hA5;
        at_cyc(k + 1); v4 = 1'b0;
        p = k + 2;
        at_cyc(p);      chk("t4_hi_nib", ld4, 8'hA0); chk("t4_en_pop", len4, 0);
        chk("t4_rs", lrs4, 1);
        at_cyc(p + 2);  chk("t4_en1_start", len4, 1);
        at_cyc(p + 4);  chk("t4_en1_end", len4, 1);
        at_cyc(p + 5);  chk("t4_hold", len4, 0); chk("t4_hold_data", ld4, 8'hA0);
        at_cyc(p + 6);  chk("t4_lo_nib", ld4, 8'h50); chk("t4_en_setup2", len4, 0);
        at_cyc(p + 8);  chk("t4_en2_start", len4, 1);
        at_cyc(p + 10); chk("t4_en2_end", len4, 1);
        at_cyc(p + 11); chk("t4_en2_off", len4, 0);
        at_cyc(p + 12); chk("t4_exec_data", ld4, 8'h50); chk("t4_exec_en", len4, 0);
        at_cyc(p + 21); chk("t4_busy_exec", busy4, 1);
        at_cyc(p + 22); chk("t4_busy_done", busy4, 0);
        chk("t4_rw", lrw4, 0);
        $display("txn t4: 4-bit byte A5 as nibbles A then 5");

        // ---------------- 5: flush during EN_HI ----------------
        wait_idle(200);
        k = cyc;
        v8 = 1'b1; rs8 = 1'b1; d8 = 8'h21;
        at_cyc(k + 1); d8 = 8'h22;
        at_cyc(k + 2); d8 = 8'h23;
        at_cyc(k + 3); v8 = 1'b0;
        chk("t5_level_queued", lvl8, 2);
        at_cyc(k + 4); chk("t5_en_before_flush", len8, 1);
        fl8 = 1'b1;
        at_cyc(k + 5); fl8 = 1'b0;
        chk("t5_level_flushed", lvl8, 0);
        chk("t5_en_continues", len8, 1);
        for (int c = k + 7; c <= k + 40; c++) begin
            at_cyc(c);
            chk("t5_no_en", len8, 0);
            if (c == k + 18) chk("t5_busy_done", busy8, 0);
        end
        chk("t5_data_kept", ld8, 8'h21);
        $display("txn t5: flush kept first byte, dropped two");

        // ---------------- 6: reset mid EN_HI ----------------
        wait_idle(100);
        k = cyc;
        v8 = 1'b1; rs8 = 1'b1; d8 = 8'h55;
        at_cyc(k + 1); v8 = 1'b0;
        v4 = 1'b1; rs4 = 1'b0; d4 = 8'h01;
        at_cyc(k + 2); v4 = 1'b0;
        at_cyc(k + 5); chk("t6_en_high", len8, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_en", len8, 0);
        chk("t6_data", ld8, 0);
        chk("t6_rs", lrs8, 0);
        chk("t6_rw", lrw8, 0);
        chk("t6_busy", busy8, 0);
        chk("t6_level", lvl8, 0);
        chk("t6_ready", ready8, 1);
        chk("t6_en4", len4, 0);
        chk("t6_data4", ld4, 0);
        chk("t6_busy4", busy4, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        at_cyc(cyc + 2);
        chk("t6_after_busy", busy8, 0);
        chk("t6_after_en", len8, 0);
        $display("txn t6: asynchronous reset mid strobe");

        // ---------------- random traffic ----------------
        for (int i = 0; i < 400; i++) begin
            v8 = ($urandom_range(0, 7) == 0) || (i >= 150 && i < 200);
            if ($urandom_range(0, 3) == 0) begin
                rs8 = 1'b0;
                d8  = 8'($urandom_range(0, 4));
            end else begin
                rs8 = 1'($urandom);
                d8  = 8'($urandom);
            end
            fl8 = ($urandom_range(0, 79) == 0);
            at_cyc(cyc + 1);
        end
        v8 = 1'b0;
        fl8 = 1'b0;
        wait_idle(3000);
        $display("txn rand: 400 cycles of random pushes and flushes");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
